prec_mul_scheduler: RTL

PREC_MUL_SCHEDULER -- requirements
Module: prec_mul_scheduler

---
 rtl/prec_mul_scheduler_pkg.sv | 15 +
 rtl/prec_tag_pipe.sv | 34 +++
 rtl/prec_mul_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/prec_mul_scheduler_pkg.sv
// rtl/prec_mul_scheduler_pkg.sv - shared types and widths for the precision multiplier scheduler
package prec_mul_scheduler_pkg;
    localparam int FP_W  = 16;
    localparam int RG_W  = 4;
    localparam int N_CH  = 2;
    localparam int CNT_W = 4;

    // ST_HOLD is the post-DONE wait while flush_req is still asserted
    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_HOLD
    } state_t;
endpackage

// File: rtl/prec_tag_pipe.sv
// rtl/prec_tag_pipe.sv - fixed-depth valid+tag shift register aligned to the multiplier latency
module prec_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);
    logic [DEPTH-1:0] vld;
    logic [TAG_W-1:0] tag [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                tag[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
endmodule

// File: rtl/prec_mul_scheduler.sv
// rtl/prec_mul_scheduler.sv - two-channel round-robin issue of FP16 multiplies with per-channel precision and flush
module prec_mul_scheduler
    import prec_mul_scheduler_pkg::*;
#(
    parameter int LAT      = 3,
    parameter int MAX_INFL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            req_valid,
    output logic [N_CH-1:0]            req_ready,
    input  logic [N_CH-1:0][FP_W-1:0]  req_a,
    input  logic [N_CH-1:0][FP_W-1:0]  req_b,
    input  logic                       cfg_we,
    input  logic                       cfg_ch,
    input  logic [RG_W-1:0]            cfg_rg,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       mul_valid,
    output logic [FP_W-1:0]            mul_a,
    output logic [FP_W-1:0]            mul_b,
    output logic [RG_W-1:0]            mul_rg,
    input  logic                       mul_res_valid,
    input  logic [FP_W-1:0]            mul_res,
    output logic [N_CH-1:0]            res_valid,
    output logic [FP_W-1:0]            res_data,
    output logic [CNT_W-1:0]           infl_cnt
);
    state_t                     state, state_nxt;
    logic [N_CH-1:0][RG_W-1:0]  prec;
    logic                       last_gnt;
    logic                       mul_ch;
    logic                       tag_vld, tag_ch;
    logic                       retire, room, issue, gnt_ch;
    logic [N_CH-1:0]            gnt;
    logic                       err_orphan;

    assign retire = mul_res_valid & tag_vld;
    assign room   = (infl_cnt < CNT_W'(MAX_INFL)) || retire;
    assign issue  = |gnt;

    // rst_n gates the grant so req_ready is low throughout reset
    always_comb begin
        gnt    = '0;
        gnt_ch = 1'b0;
        if (rst_n && state == ST_RUN && room && |req_valid) begin
            if (&req_valid) gnt_ch = ~last_gnt;
            else            gnt_ch = req_valid[1];
            gnt[gnt_ch] = 1'b1;
        end
    end
    assign req_ready = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_rg    <= '0;
            mul_ch    <= 1'b0;
            last_gnt  <= 1'b1;
        end else begin
            mul_valid <= issue;
            if (issue) begin
                mul_a    <= req_a[gnt_ch];
                mul_b    <= req_b[gnt_ch];
                mul_rg   <= prec[gnt_ch];
                mul_ch   <= gnt_ch;
                last_gnt <= gnt_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prec       <= '0;
            infl_cnt   <= '0;
            err_orphan <= 1'b0;
            state      <= ST_RUN;
        end else begin
            if (cfg_we) prec[cfg_ch] <= cfg_rg;
            if (issue && !retire)      infl_cnt <= infl_cnt + 1'b1;
            else if (!issue && retire) infl_cnt <= infl_cnt - 1'b1;
            if (mul_res_valid && !tag_vld) err_orphan <= 1'b1;
            state <= state_nxt;
        end
    end

    // DRAIN completes on the cycle the last in-flight result retires
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (infl_cnt == '0 || (infl_cnt == CNT_W'(1) && retire)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = flush_req ? ST_HOLD : ST_RUN;
            ST_HOLD:  if (!flush_req) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end
    assign flush_done = (state == ST_DONE);

    prec_tag_pipe #(
        .DEPTH (LAT),
        .TAG_W (1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mul_valid),
        .in_tag    (mul_ch),
        .out_valid (tag_vld),
        .out_tag   (tag_ch)
    );

    always_comb begin
        res_valid         = '0;
        res_valid[tag_ch] = retire;
    end
    assign res_data = mul_res;
endmodule
